adder_share_arbiter: RTL and testbench

Round-robin scheduler that shares one combinational 16-bit approximate ripple-carry adder between two requesters. Each request passes a valid/ready operand handshake. The block drives the adder operand bus from registers and waits a programmable settle time for the ripple chain. It then captures the 17-bit sum and returns it with the requester ID over a valid/ready result handshake. An optional monitor compares each approximate result against an exact sum and records error statistics for power/accuracy characterisation runs.

---
 rtl/adder_share_arbiter.sv | 166 ++++++++++++++++
 tb/tb_adder_share_arbiter.sv | 232 +++++++++++++++++++++++
 2 files changed

// File: rtl/adder_share_arbiter.sv
// adder_share_arbiter
//   Round-robin scheduler that shares one external combinational adder between
//   two requesters. Each accepted request's operands are registered onto the
//   adder bus. After ADD_LAT settle cycles the sum is captured and returned
//   with the requester index.
//
// Optional feature macro: ADDER_ERR_MON_EN
//   When defined, each captured sum is compared against an exact sum, and the
//   block keeps error statistics (err_cnt, err_max). When undefined, both
//   statistics are tied to zero and err_clr is ignored.
//
// Ports
//   clk, rst_n            clock, asynchronous active-low reset
//   req_valid/req_ready   per-requester operand handshake (2 bits)
//   req_a, req_b          packed operands, requester i at [i*W +: W]
//   add_a, add_b          registered operands to the external adder
//   add_sum               external adder result (W+1 bits)
//   res_valid/res_ready   result handshake
//   res_sum, res_id       captured sum and its requester index
//   err_clr               synchronous clear of the error statistics
//   err_cnt, err_max      inexact-result count (saturating), max |error|
module adder_share_arbiter #(
  parameter int unsigned W       = 16,
  parameter int unsigned ADD_LAT = 1
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic [1:0]     req_valid,
  output logic [1:0]     req_ready,
  input  logic [2*W-1:0] req_a,
  input  logic [2*W-1:0] req_b,
  output logic [W-1:0]   add_a,
  output logic [W-1:0]   add_b,
  input  logic [W:0]     add_sum,
  output logic           res_valid,
  input  logic           res_ready,
  output logic [W:0]     res_sum,
  output logic           res_id,
  input  logic           err_clr,
  output logic [15:0]    err_cnt,
  output logic [W:0]     err_max
);

  typedef enum logic [1:0] {StIdle, StIssue, StResp} state_e;

  localparam logic [3:0] LatInit = 4'(ADD_LAT);

  state_e         state_q, state_d;
  logic           last_q;
  logic           id_q;
  logic [3:0]     cnt_q;
  logic [W-1:0]   add_a_q, add_b_q;
  logic           res_valid_q;
  logic [W:0]     res_sum_q;
  logic           res_id_q;

  logic           grant_en;
  logic           gnt_id;
  logic           accept;
  logic           capture;

  // Grant window: idle, or the cycle the current result is being consumed.
  assign grant_en = (state_q == StIdle) || ((state_q == StResp) && res_ready);

  always_comb begin
    gnt_id = 1'b0;
    if (req_valid == 2'b10) begin
      gnt_id = 1'b1;
    end else if (req_valid == 2'b11) begin
      gnt_id = ~last_q;
    end
  end

  assign accept  = grant_en && (req_valid != 2'b00);
  assign capture = (state_q == StIssue) && (cnt_q == 4'd1);

  // Gated by rst_n so no grant is advertised while reset is asserted.
  assign req_ready = (accept && rst_n) ? (2'b01 << gnt_id) : 2'b00;

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:  if (accept) state_d = StIssue;
      StIssue: if (capture) state_d = StResp;
      StResp:  if (res_ready) state_d = accept ? StIssue : StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= StIdle;
      last_q      <= 1'b1;
      id_q        <= 1'b0;
      cnt_q       <= '0;
      add_a_q     <= '0;
      add_b_q     <= '0;
      res_valid_q <= 1'b0;
      res_sum_q   <= '0;
      res_id_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      if (accept) begin
        add_a_q <= gnt_id ? req_a[2*W-1:W] : req_a[W-1:0];
        add_b_q <= gnt_id ? req_b[2*W-1:W] : req_b[W-1:0];
        last_q  <= gnt_id;
        id_q    <= gnt_id;
        cnt_q   <= LatInit;
      end else if (state_q == StIssue) begin
        cnt_q <= cnt_q - 4'd1;
      end
      if (capture) begin
        res_sum_q   <= add_sum;
        res_id_q    <= id_q;
        res_valid_q <= 1'b1;
      end else if ((state_q == StResp) && res_ready) begin
        res_valid_q <= 1'b0;
      end
    end
  end

  assign add_a     = add_a_q;
  assign add_b     = add_b_q;
  assign res_valid = res_valid_q;
  assign res_sum   = res_sum_q;
  assign res_id    = res_id_q;

`ifdef ADDER_ERR_MON_EN
  logic [W:0]  exact;
  logic [W:0]  err_abs;
  logic [15:0] err_cnt_q;
  logic [W:0]  err_max_q;

  always_comb begin
    exact   = {1'b0, add_a_q} + {1'b0, add_b_q};
    err_abs = (exact >= add_sum) ? (exact - add_sum) : (add_sum - exact);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      err_cnt_q <= '0;
      err_max_q <= '0;
    end else if (err_clr) begin
      // Clear takes priority over a same-cycle capture.
      err_cnt_q <= '0;
      err_max_q <= '0;
    end else if (capture) begin
      if ((err_abs != '0) && (err_cnt_q != 16'hFFFF)) begin
        err_cnt_q <= err_cnt_q + 16'd1;
      end
      if (err_abs > err_max_q) begin
        err_max_q <= err_abs;
      end
    end
  end

  assign err_cnt = err_cnt_q;
  assign err_max = err_max_q;
`else
  logic unused_err_clr;
  assign unused_err_clr = err_clr;
  assign err_cnt        = '0;
  assign err_max        = '0;
`endif

endmodule

// File: tb/tb_adder_share_arbiter.sv
module tb_adder_share_arbiter;

`ifdef ADDER_ERR_MON_EN
  localparam bit Mon = 1'b1;
`else
  localparam bit Mon = 1'b0;
`endif

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n;
  logic        err_clr;
  logic        corrupt;

  // DUT with ADD_LAT=1
  logic [1:0]  rv1, rr1;
  logic [31:0] req_a1, req_b1;
  logic [15:0] add_a1, add_b1;
  logic [16:0] sum1, res_sum1, err_max1;
  logic        res_valid1, res_ready1, res_id1;
  logic [15:0] err_cnt1;

  // DUT with ADD_LAT=4
  logic [1:0]  rv4, rr4;
  logic [31:0] req_a4, req_b4;
  logic [15:0] add_a4, add_b4;
  logic [16:0] sum4, res_sum4, err_max4;
  logic        res_valid4, res_ready4, res_id4;
  logic [15:0] err_cnt4;

  int passed = 0;
  int total  = 0;

  // 12 approximate low cells (sum = b bit, carry = a bit), 4 exact upper cells.
  function automatic logic [16:0] model(input logic [15:0] a, input logic [15:0] b);
    logic [4:0] hi;
    hi = {1'b0, a[15:12]} + {1'b0, b[15:12]} + {4'b0, a[11]};
    return {hi, b[11:0]};
  endfunction

  assign sum1 = model(add_a1, add_b1);
  assign sum4 = corrupt ? 17'h1FFFF : model(add_a4, add_b4);

  adder_share_arbiter #(.W(16), .ADD_LAT(1)) dut1 (
    .clk(clk), .rst_n(rst_n), .req_valid(rv1), .req_ready(rr1), .req_a(req_a1),
    .req_b(req_b1), .add_a(add_a1), .add_b(add_b1), .add_sum(sum1),
    .res_valid(res_valid1), .res_ready(res_ready1), .res_sum(res_sum1), .res_id(res_id1),
    .err_clr(err_clr), .err_cnt(err_cnt1), .err_max(err_max1)
  );

  adder_share_arbiter #(.W(16), .ADD_LAT(4)) dut4 (
    .clk(clk), .rst_n(rst_n), .req_valid(rv4), .req_ready(rr4), .req_a(req_a4),
    .req_b(req_b4), .add_a(add_a4), .add_b(add_b4), .add_sum(sum4),
    .res_valid(res_valid4), .res_ready(res_ready4), .res_sum(res_sum4), .res_id(res_id4),
    .err_clr(err_clr), .err_cnt(err_cnt4), .err_max(err_max4)
  );

  task automatic test_reset();
    rst_n = 1'b0; err_clr = 1'b0; corrupt = 1'b0;
    rv1 = 2'b11; req_a1 = '0; req_b1 = '0; res_ready1 = 1'b0;
    rv4 = 2'b00; req_a4 = '0; req_b4 = '0; res_ready4 = 1'b0;
    repeat (2) @(negedge clk);
    total++; if (rr1 !== 2'b00) $display("FAIL reset_req_ready got %h exp 0", rr1); else passed++;
    total++; if (add_a1 !== 16'h0) $display("FAIL reset_add_a got %h exp 0", add_a1); else passed++;
    total++; if (add_b1 !== 16'h0) $display("FAIL reset_add_b got %h exp 0", add_b1); else passed++;
    total++; if (res_valid1 !== 1'b0) $display("FAIL reset_res_valid got %b", res_valid1); else passed++;
    total++; if (res_sum1 !== 17'h0) $display("FAIL reset_res_sum got %h exp 0", res_sum1); else passed++;
    total++; if (res_id1 !== 1'b0) $display("FAIL reset_res_id got %b exp 0", res_id1); else passed++;
    total++; if (err_cnt1 !== 16'h0) $display("FAIL reset_err_cnt got %h exp 0", err_cnt1); else passed++;
    total++; if (err_max1 !== 17'h0) $display("FAIL reset_err_max got %h exp 0", err_max1); else passed++;
    rv1 = 2'b00;
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_single();
    req_a1 = 32'h0000_0003; req_b1 = 32'h0000_0005; rv1 = 2'b01;
    #1;
    total++; if (rr1 !== 2'b01) $display("FAIL single_grant got %b exp 01", rr1); else passed++;
    @(negedge clk);
    rv1 = 2'b00;
    total++; if (res_valid1 !== 1'b0) $display("FAIL single_early_valid got %b exp 0", res_valid1); else passed++;
    total++; if (add_a1 !== 16'h0003) $display("FAIL single_add_a got %h exp 0003", add_a1); else passed++;
    total++; if (add_b1 !== 16'h0005) $display("FAIL single_add_b got %h exp 0005", add_b1); else passed++;
    @(negedge clk);
    total++; if (res_valid1 !== 1'b1) $display("FAIL single_valid got %b exp 1", res_valid1); else passed++;
    total++; if (res_sum1 !== 17'h00005) $display("FAIL single_sum got %h exp 00005", res_sum1); else passed++;
    total++; if (res_id1 !== 1'b0) $display("FAIL single_id got %b exp 0", res_id1); else passed++;
    total++; if (err_cnt1 !== (Mon ? 16'd1 : 16'd0)) $display("FAIL single_err_cnt got %0d exp %0d", err_cnt1, Mon ? 1 : 0); else passed++;
    total++; if (err_max1 !== (Mon ? 17'd3 : 17'd0)) $display("FAIL single_err_max got %0d exp %0d", err_max1, Mon ? 3 : 0); else passed++;
    res_ready1 = 1'b1;
    @(negedge clk);
    total++; if (res_valid1 !== 1'b0) $display("FAIL single_valid_drop got %b exp 0", res_valid1); else passed++;
    total++; if (add_a1 !== 16'h0003) $display("FAIL single_add_a_hold got %h exp 0003", add_a1); else passed++;
  endtask

  task automatic test_contention();
    int          got;
    logic        exp_id;
    logic [16:0] exp_sum;
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    req_a1 = {16'h1000, 16'h0010}; req_b1 = {16'h2000, 16'h0001};
    res_ready1 = 1'b1; rv1 = 2'b11;
    got = 0;
    for (int c = 0; c < 40 && got < 4; c++) begin
      @(negedge clk);
      if (res_valid1) begin
        exp_id  = 1'(got % 2);
        exp_sum = exp_id ? 17'h03000 : 17'h00001;
        total++; if (res_id1 !== exp_id) $display("FAIL contention_id[%0d] got %b exp %b", got, res_id1, exp_id); else passed++;
        total++; if (res_sum1 !== exp_sum) $display("FAIL contention_sum[%0d] got %h exp %h", got, res_sum1, exp_sum); else passed++;
        got++;
        if (got == 4) rv1 = 2'b00;
      end
    end
    total++; if (got !== 4) $display("FAIL contention_count got %0d exp 4", got); else passed++;
    repeat (2) @(negedge clk);
  endtask

  task automatic test_backpressure();
    int seen;
    res_ready1 = 1'b0;
    req_a1 = {16'h1000, 16'h0800}; req_b1 = {16'h2000, 16'h0001}; rv1 = 2'b01;
    seen = 0;
    for (int c = 0; c < 10 && seen == 0; c++) begin
      @(negedge clk);
      if (res_valid1) seen = 1;
    end
    total++; if (seen !== 1) $display("FAIL bp_result_timeout got %0d exp 1", seen); else passed++;
    rv1 = 2'b10;
    for (int k = 0; k < 5; k++) begin
      #1;
      total++; if (res_sum1 !== 17'h01001) $display("FAIL bp_sum_hold[%0d] got %h exp 01001", k, res_sum1); else passed++;
      total++; if (res_id1 !== 1'b0) $display("FAIL bp_id_hold[%0d] got %b exp 0", k, res_id1); else passed++;
      total++; if (res_valid1 !== 1'b1) $display("FAIL bp_valid_hold[%0d] got %b exp 1", k, res_valid1); else passed++;
      total++; if (rr1 !== 2'b00) $display("FAIL bp_no_grant[%0d] got %b exp 00", k, rr1); else passed++;
      @(negedge clk);
    end
    res_ready1 = 1'b1;
    #1;
    total++; if (rr1 !== 2'b10) $display("FAIL bp_release_grant got %b exp 10", rr1); else passed++;
    @(negedge clk);
    rv1 = 2'b00;
    total++; if (add_a1 !== 16'h1000) $display("FAIL bp_next_add_a got %h exp 1000", add_a1); else passed++;
    @(negedge clk);
    total++; if (res_valid1 !== 1'b1) $display("FAIL bp_next_valid got %b exp 1", res_valid1); else passed++;
    total++; if (res_sum1 !== 17'h03000) $display("FAIL bp_next_sum got %h exp 03000", res_sum1); else passed++;
    total++; if (res_id1 !== 1'b1) $display("FAIL bp_next_id got %b exp 1", res_id1); else passed++;
    @(negedge clk);
  endtask

  task automatic test_exact_upper();
    // Stats since last reset: two req0 results err 0x10, one err 0x800.
    req_a1 = {16'h0000, 16'h8000}; req_b1 = {16'h0000, 16'h8000};
    rv1 = 2'b01; res_ready1 = 1'b1;
    @(negedge clk);
    rv1 = 2'b00;
    @(negedge clk);
    total++; if (res_valid1 !== 1'b1) $display("FAIL exact_valid got %b exp 1", res_valid1); else passed++;
    total++; if (res_sum1 !== 17'h10000) $display("FAIL exact_sum got %h exp 10000", res_sum1); else passed++;
    total++; if (err_cnt1 !== (Mon ? 16'd3 : 16'd0)) $display("FAIL exact_err_cnt got %0d exp %0d", err_cnt1, Mon ? 3 : 0); else passed++;
    total++; if (err_max1 !== (Mon ? 17'h800 : 17'h0)) $display("FAIL exact_err_max got %h exp %h", err_max1, Mon ? 17'h800 : 17'h0); else passed++;
    @(negedge clk);
  endtask

  task automatic test_latency();
    req_a4 = 32'h0000_0003; req_b4 = 32'h0000_0005; rv4 = 2'b01; res_ready4 = 1'b0;
    #1;
    total++; if (rr4 !== 2'b01) $display("FAIL lat_grant got %b exp 01", rr4); else passed++;
    @(negedge clk);
    rv4 = 2'b00;
    corrupt = 1'b1;
    total++; if (res_valid4 !== 1'b0) $display("FAIL lat_valid_c1 got %b exp 0", res_valid4); else passed++;
    for (int k = 2; k <= 4; k++) begin
      @(negedge clk);
      if (k == 3) corrupt = 1'b0;
      total++; if (res_valid4 !== 1'b0) $display("FAIL lat_valid_c%0d got %b exp 0", k, res_valid4); else passed++;
    end
    @(negedge clk);
    total++; if (res_valid4 !== 1'b1) $display("FAIL lat_valid_c5 got %b exp 1", res_valid4); else passed++;
    total++; if (res_sum4 !== 17'h00005) $display("FAIL lat_sum got %h exp 00005", res_sum4); else passed++;
    total++; if (res_id4 !== 1'b0) $display("FAIL lat_id got %b exp 0", res_id4); else passed++;
    res_ready4 = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_reset_mid();
    req_a1 = {16'h1000, 16'h0003}; req_b1 = {16'h2000, 16'h0005};
    rv1 = 2'b11; res_ready1 = 1'b0;
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    total++; if (rr1 !== 2'b00) $display("FAIL mid_rst_ready got %b exp 00", rr1); else passed++;
    total++; if (add_a1 !== 16'h0) $display("FAIL mid_rst_add_a got %h exp 0", add_a1); else passed++;
    total++; if (res_valid1 !== 1'b0) $display("FAIL mid_rst_valid got %b exp 0", res_valid1); else passed++;
    total++; if (res_sum1 !== 17'h0) $display("FAIL mid_rst_sum got %h exp 0", res_sum1); else passed++;
    total++; if (err_cnt1 !== 16'h0) $display("FAIL mid_rst_err_cnt got %h exp 0", err_cnt1); else passed++;
    total++; if (err_max1 !== 17'h0) $display("FAIL mid_rst_err_max got %h exp 0", err_max1); else passed++;
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    total++; if (rr1 !== 2'b01) $display("FAIL mid_rst_first_grant got %b exp 01", rr1); else passed++;
    err_clr = 1'b1;
    @(negedge clk);
    total++; if (res_valid1 !== 1'b0) $display("FAIL mid_rst_issue_valid got %b exp 0", res_valid1); else passed++;
    @(negedge clk);
    err_clr = 1'b0;
    total++; if (res_valid1 !== 1'b1) $display("FAIL mid_rst_valid2 got %b exp 1", res_valid1); else passed++;
    total++; if (res_sum1 !== 17'h00005) $display("FAIL mid_rst_sum2 got %h exp 00005", res_sum1); else passed++;
    total++; if (res_id1 !== 1'b0) $display("FAIL mid_rst_id2 got %b exp 0", res_id1); else passed++;
    total++; if (err_cnt1 !== 16'h0) $display("FAIL clr_wins_err_cnt got %0d exp 0", err_cnt1); else passed++;
    total++; if (err_max1 !== 17'h0) $display("FAIL clr_wins_err_max got %0d exp 0", err_max1); else passed++;
    rv1 = 2'b00; res_ready1 = 1'b1;
    @(negedge clk);
  endtask

  initial begin
    test_reset();
    test_single();
    test_contention();
    test_backpressure();
    test_exact_upper();
    test_latency();
    test_reset_mid();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
